fosfor_present_hostif: RTL

FOSFOR_PRESENT_HOSTIF -- requirements
Module: fosfor_present_hostif

---
 rtl/fosfor_present_hostif_pkg.sv | 27 ++
 rtl/fosfor_present_seq.sv | 78 +++++++
 rtl/fosfor_present_hostif.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fosfor_present_hostif_pkg.sv
// Shared constants for the PRESENT host interface: host port codes, command
// bit positions, register map anchors and the sequencer state encoding.
package fosfor_present_hostif_pkg;

  // Host port select codes on Addr_ib.
  localparam logic [1:0] PORT_IDLE    = 2'b00;
  localparam logic [1:0] PORT_CMD     = 2'b01;
  localparam logic [1:0] PORT_DATA_LO = 2'b10;
  localparam logic [1:0] PORT_DATA_HI = 2'b11;

  // Bit positions inside the command register.
  localparam int CMD_LATCH   = 0;
  localparam int CMD_ADVANCE = 1;
  localparam int CMD_WRITE   = 2;
  localparam int CMD_START   = 3;

  // Register map anchors.
  localparam logic [7:0] KEY_OFFSET    = 8'h10;
  localparam logic [7:0] TEST_REG_ADDR = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fosfor_present_seq.sv
// Core run sequencer: issues the start pulse, waits for the core to report
// ready, aborts after TIMEOUT cycles and keeps the sticky error flag.
module fosfor_present_seq
  import fosfor_present_hostif_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_req_i,
  input  logic wr_blocked_i,
  input  logic ready_i,
  output logic start_o,
  output logic run_o,
  output logic done_o,
  output logic error_o
);

  seq_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       error_q, error_d;

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state, counter and error-flag logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    start_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req_i) begin
          start_o = 1'b1;
          error_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (start_req_i || wr_blocked_i) error_d = 1'b1;
        // cnt_q==0 is the first RUN cycle, one cycle after the start pulse;
        // the core result is only trusted from the second cycle on.
        if (ready_i && (cnt_q != 8'd0)) begin
          state_d = ST_DONE;
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset cycle must never launch the core.
    if (rst_i) start_o = 1'b0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign run_o   = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign error_o = error_q;

endmodule

// File: rtl/fosfor_present_hostif.sv
// Nibble-wide host port to a PRESENT block cipher core: command register,
// 8-bit register address, byte-lane text/key loading, cipher readback.
module fosfor_present_hostif
  import fosfor_present_hostif_pkg::*;
#(
  parameter int KEY_BITS = 80,
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic                  Clk_ik,
  input  logic                  Reset_ir,
  input  logic [1:0]            Addr_ib,
  input  logic [3:0]            Data_ib,
  output logic [7:0]            Data_ob,
  output logic [63:0]           PlainText_ob,
  output logic [7:0]            TextRegEnable_ob,
  output logic [KEY_BITS-1:0]   Key_ob,
  output logic [KEY_BITS/8-1:0] KeyRegEnable_ob,
  output logic                  Start_o,
  input  logic                  Ready_i,
  input  logic [63:0]           CipherText_ib
);

  localparam int KEY_BYTES = KEY_BITS / 8;

  logic [3:0] cmd_q, cmd_d;
  logic [7:0] input_data_q, input_data_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] test_q, test_d;
  logic [7:0] key_idx, rd_data, status;
  logic       text_hit, key_hit, wr_cmd, wr_blocked;
  logic       run, done, error;

  assign wr_cmd     = cmd_q[CMD_WRITE];
  assign text_hit   = (reg_addr_q[7:3] == 5'd0);
  assign key_idx    = reg_addr_q - KEY_OFFSET;
  assign key_hit    = (reg_addr_q >= KEY_OFFSET) && (key_idx < 8'(KEY_BYTES));
  assign wr_blocked = wr_cmd && run && (text_hit || key_hit);

  // Host port decode: the command register clears unless reloaded.
  always_comb begin
    cmd_d        = 4'd0;
    input_data_d = input_data_q;
    case (Addr_ib)
      PORT_IDLE:    ;
      PORT_CMD:     cmd_d = Data_ib;
      PORT_DATA_LO: input_data_d[3:0] = Data_ib;
      PORT_DATA_HI: input_data_d[7:4] = Data_ib;
    endcase
  end

  // Address and test-register update; the write uses the old address and a
  // latch in the same command overrides any advance.
  always_comb begin
    reg_addr_d = reg_addr_q;
    test_d     = test_q;
    if (wr_cmd && (reg_addr_q == TEST_REG_ADDR)) test_d = input_data_q;
    if (cmd_q[CMD_LATCH]) begin
      reg_addr_d = input_data_q;
    end else if (cmd_q[CMD_ADVANCE] || (wr_cmd && (AUTO_INC != 0))) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end
  end

  // Host-side registers with synchronous reset.
  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      cmd_q        <= 4'd0;
      input_data_q <= 8'd0;
      reg_addr_q   <= 8'd0;
      test_q       <= 8'd0;
    end else begin
      cmd_q        <= cmd_d;
      input_data_q <= input_data_d;
      reg_addr_q   <= reg_addr_d;
      test_q       <= test_d;
    end
  end

  // One-hot byte-lane write strobes toward the core, suppressed while running.
  always_comb begin
    PlainText_ob     = '0;
    TextRegEnable_ob = '0;
    Key_ob           = '0;
    KeyRegEnable_ob  = '0;
    if (wr_cmd && !run && !Reset_ir) begin
      if (text_hit) begin
        TextRegEnable_ob[reg_addr_q[2:0]]            = 1'b1;
        PlainText_ob[{reg_addr_q[2:0], 3'b000} +: 8] = input_data_q;
      end
      for (int i = 0; i < KEY_BYTES; i++) begin
        if (key_hit && (key_idx == 8'(i))) begin
          KeyRegEnable_ob[i] = 1'b1;
          Key_ob[8*i +: 8]   = input_data_q;
        end
      end
    end
  end

  // Host read mux: register data on the data ports, status otherwise.
  always_comb begin
    rd_data = 8'h00;
    if (text_hit) rd_data = CipherText_ib[{reg_addr_q[2:0], 3'b000} +: 8];
    else if (reg_addr_q == TEST_REG_ADDR) rd_data = test_q;
    status  = {((KEY_BITS == 128) ? 1'b1 : 1'b0), 3'b000, error, done, run, Ready_i};
    Data_ob = Addr_ib[1] ? rd_data : status;
  end

  fosfor_present_seq #(
    .TIMEOUT(TIMEOUT)
  ) u_seq (
    .clk_i       (Clk_ik),
    .rst_i       (Reset_ir),
    .start_req_i (cmd_q[CMD_START]),
    .wr_blocked_i(wr_blocked),
    .ready_i     (Ready_i),
    .start_o     (Start_o),
    .run_o       (run),
    .done_o      (done),
    .error_o     (error)
  );

endmodule
